uart_data_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_data_tx_if.sv | 25 ++
 rtl/uart_byte_tx.sv | 93 +++++++++
 rtl/uart_data_tx.sv | 125 ++++++++++++
 tb/tb_uart_data_tx.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART word transmitter.
//   CLK_FREQ  : system clock frequency the baud divisors are derived for
//   BAUD_DIV  : clocks per bit, indexed by the 3-bit baud select
//   tx_state_e: word sequencer states
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD_CNT_W = 13;

  // Nearest-integer divisor of CLK_FREQ by the baud rate.
  function automatic int unsigned round_div(input int unsigned rate);
    return (CLK_FREQ + rate / 2) / rate;
  endfunction

  // 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600 baud
  localparam logic [BAUD_CNT_W-1:0] BAUD_DIV [8] = '{
    BAUD_CNT_W'(round_div(9600)),
    BAUD_CNT_W'(round_div(19200)),
    BAUD_CNT_W'(round_div(38400)),
    BAUD_CNT_W'(round_div(57600)),
    BAUD_CNT_W'(round_div(115200)),
    BAUD_CNT_W'(round_div(230400)),
    BAUD_CNT_W'(round_div(460800)),
    BAUD_CNT_W'(round_div(921600))
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_data_tx_if.sv
// Host-side bundle of the UART word transmitter.
//   data/send_en/baud_set : word, one-cycle request and baud select from the host
//   uart_tx               : serial line (idle high)
//   tx_done               : one-cycle pulse when the whole word has been sent
//   uart_state            : high while a word is on the line
interface uart_data_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  send_en;
  logic [2:0]            baud_set;
  logic                  uart_tx;
  logic                  tx_done;
  logic                  uart_state;

  modport master (
    output data, send_en, baud_set,
    input  uart_tx, tx_done, uart_state
  );

  modport slave (
    input  data, send_en, baud_set,
    output uart_tx, tx_done, uart_state
  );
endinterface

// File: rtl/uart_byte_tx.sv
// Single 8N1 byte transmitter: start bit, d0..d7, stop bit, each held for the
// divisor selected by baud_set (latched together with data on acceptance).
//   clk, reset_n : clock, synchronous active-low reset
//   data         : byte to send, sampled on acceptance
//   send_en      : request; accepted when idle or on the edge the stop bit ends
//   baud_set     : baud select, sampled on acceptance
//   uart_tx      : registered serial output, idle high
//   tx_done      : strobe during the last clock of the stop bit, so a new
//                  request raised in that same cycle starts with no gap
//   uart_state   : high while a frame is in progress
module uart_byte_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       send_en,
  input  logic [2:0] baud_set,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       uart_state
);

  logic                  busy_q, busy_d;
  logic [3:0]            bit_q, bit_d;   // 0 start, 1..8 data, 9 stop
  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic [BAUD_CNT_W-1:0] div_q, div_d;
  logic [7:0]            data_q, data_d;
  logic                  tx_q, tx_d;

  logic bit_end;
  logic finish;
  logic accept;

  assign bit_end = busy_q && (cnt_q == div_q - BAUD_CNT_W'(1));
  assign finish  = bit_end && (bit_q == 4'd9);
  assign accept  = send_en && (!busy_q || finish);

  always_comb begin
    busy_d = busy_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    data_d = data_q;
    tx_d   = tx_q;
    if (accept) begin
      busy_d = 1'b1;
      bit_d  = 4'd0;
      cnt_d  = '0;
      div_d  = BAUD_DIV[baud_set];
      data_d = data;
      tx_d   = 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          bit_d  = 4'd0;
          tx_d   = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          // Entering bit_q+1: data bit bit_q, or the stop bit after d7.
          tx_d  = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
        end
      end else begin
        cnt_d = cnt_q + BAUD_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      bit_q  <= 4'd0;
      cnt_q  <= '0;
      div_q  <= BAUD_DIV[0];
      data_q <= 8'd0;
      tx_q   <= 1'b1;
    end else begin
      busy_q <= busy_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      data_q <= data_d;
      tx_q   <= tx_d;
    end
  end

  assign uart_tx    = tx_q;
  assign tx_done    = finish;
  assign uart_state = busy_q;

endmodule

// File: rtl/uart_data_tx.sv
// Multi-byte UART transmitter: latches a DATA_WIDTH word on an accepted
// send_en and sends it as BYTES back-to-back 8N1 frames.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : host bundle (data, send_en, baud_set in; uart_tx, tx_done,
//                  uart_state out)
// MSB_FIRST=0 sends data[7:0] first, MSB_FIRST=1 sends the top byte first.
module uart_data_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input logic           clk,
  input logic           reset_n,
  uart_data_tx_if.slave bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] StIdle = IDLE;
  localparam logic [1:0] StSend = SEND;
  localparam logic [1:0] StDone = DONE;

  logic [1:0]            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [2:0]            baud_q, baud_d;

  logic [7:0]      in_bytes   [BYTES];
  logic [7:0]      word_bytes [BYTES];
  logic            accept;
  logic            last_byte;
  logic [IdxW-1:0] nxt_idx;
  logic [IdxW-1:0] byte_sel;
  logic [IdxW-1:0] slot;

  logic       byte_send;
  logic [7:0] byte_data;
  logic [2:0] byte_baud;
  logic       byte_tx;
  logic       byte_done;
  logic       byte_busy;

  always_comb begin
    for (int i = 0; i < int'(BYTES); i++) begin
      in_bytes[i]   = bus.data[8*i +: 8];
      word_bytes[i] = word_q[8*i +: 8];
    end
  end

  // DONE also counts as free, so a request in the tx_done cycle is taken.
  assign accept    = bus.send_en && (state_q != StSend);
  assign last_byte = (idx_q == IdxW'(BYTES - 1));
  assign nxt_idx   = last_byte ? '0 : idx_q + IdxW'(1);

  // Byte 0 comes straight from the bus on acceptance; later bytes come from
  // the latched word, requested on the same cycle the previous stop bit ends.
  assign byte_send = accept || ((state_q == StSend) && byte_done && !last_byte);
  assign byte_sel  = accept ? '0 : nxt_idx;
  assign slot      = MSB_FIRST ? (IdxW'(BYTES - 1) - byte_sel) : byte_sel;
  assign byte_data = accept ? in_bytes[slot] : word_bytes[slot];
  assign byte_baud = accept ? bus.baud_set : baud_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    baud_d  = baud_q;
    case (state_q)
      StSend: begin
        if (byte_done) begin
          if (last_byte) begin
            state_d = StDone;
            idx_d   = '0;
          end else begin
            idx_d = nxt_idx;
          end
        end
      end
      default: begin
        if (accept) begin
          state_d = StSend;
          idx_d   = '0;
          word_d  = bus.data;
          baud_d  = bus.baud_set;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
      baud_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      baud_q  <= baud_d;
    end
  end

  uart_byte_tx u_byte_tx (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (byte_data),
    .send_en    (byte_send),
    .baud_set   (byte_baud),
    .uart_tx    (byte_tx),
    .tx_done    (byte_done),
    .uart_state (byte_busy)
  );

  // Frames run back-to-back, so the byte engine is busy exactly while a word
  // is in flight.
  assign bus.uart_tx    = byte_tx;
  assign bus.uart_state = byte_busy;
  assign bus.tx_done    = (state_q == StDone);

endmodule

// File: tb/tb_uart_data_tx.sv
module tb_uart_data_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  uart_data_tx_if #(.DATA_WIDTH(32)) if_l ();
  uart_data_tx_if #(.DATA_WIDTH(32)) if_m ();

  uart_data_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_l)
  );

  uart_data_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_m)
  );

  bit   sel = 1'b0;
  logic obs_tx, obs_done, obs_state;
  assign obs_tx    = sel ? if_m.uart_tx    : if_l.uart_tx;
  assign obs_done  = sel ? if_m.tx_done    : if_l.tx_done;
  assign obs_state = sel ? if_m.uart_state : if_l.uart_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          msb;       // send through the MSB_FIRST=1 instance
    logic [2:0]  baud;
    logic [31:0] data;
    int          n;         // expected clocks per bit
    logic [31:0] seq;       // expected bytes in line order, first in [31:24]
    bit          poke;      // busy send_en + baud change mid-word
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit msb, input logic [31:0] d, input logic [2:0] b,
                       input logic en);
    if (msb) begin
      if_m.data = d; if_m.baud_set = b; if_m.send_en = en;
    end else begin
      if_l.data = d; if_l.baud_set = b; if_l.send_en = en;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after an edge; send_en is raised for the current cycle.
  task automatic run_word(input int vi, input vec_t v);
    logic [31:0] seq;
    logic [7:0]  by;
    logic        expb;
    int          line_err, ctl_err;
    seq = v.seq;
    sel = v.msb;
    drive(v.msb, v.data, v.baud, 1'b1);
    step();
    drive(v.msb, v.data, v.baud, 1'b0);
    for (int b = 0; b < 40; b++) begin
      by = seq[31 - 8 * (b / 10) -: 8];
      if (b % 10 == 0)      expb = 1'b0;
      else if (b % 10 == 9) expb = 1'b1;
      else                  expb = by[(b % 10) - 1];
      line_err = 0;
      ctl_err  = 0;
      for (int c = 0; c < v.n; c++) begin
        if (v.poke && b == 15 && c == 3) drive(v.msb, ~v.data, 3'd0, 1'b1);
        if (v.poke && b == 15 && c == 4) drive(v.msb, ~v.data, 3'd0, 1'b0);
        if (obs_tx !== expb) line_err++;
        if (obs_state !== 1'b1 || obs_done !== 1'b0) ctl_err++;
        step();
      end
      chk($sformatf("v%0d bit%0d line_err_cycles", vi, b), line_err, 0);
      chk($sformatf("v%0d bit%0d ctl_err_cycles", vi, b), ctl_err, 0);
    end
    chk($sformatf("v%0d done_pulse", vi), {29'd0, obs_done, obs_state, obs_tx}, 32'b101);
    step();
    chk($sformatf("v%0d after_done", vi), {29'd0, obs_done, obs_state, obs_tx}, 32'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int err;
    vecs[0] = '{msb: 1'b0, baud: 3'd4, data: 32'h01234567, n: 434, seq: 32'h67452301, poke: 1'b0};
    vecs[1] = '{msb: 1'b0, baud: 3'd7, data: 32'h12345678, n: 54,  seq: 32'h78563412, poke: 1'b0};
    vecs[2] = '{msb: 1'b0, baud: 3'd7, data: 32'h23456789, n: 54,  seq: 32'h89674523, poke: 1'b1};
    vecs[3] = '{msb: 1'b1, baud: 3'd7, data: 32'h01234567, n: 54,  seq: 32'h01234567, poke: 1'b0};
    vecs[4] = '{msb: 1'b0, baud: 3'd6, data: 32'hA5C3F00F, n: 109, seq: 32'h0FF0C3A5, poke: 1'b0};
    vecs[5] = '{msb: 1'b0, baud: 3'd5, data: 32'h80000001, n: 217, seq: 32'h01000080, poke: 1'b0};
    vecs[6] = '{msb: 1'b1, baud: 3'd5, data: 32'hDEADBEEF, n: 217, seq: 32'hDEADBEEF, poke: 1'b1};

    drive(1'b0, 32'h0, 3'd0, 1'b0);
    drive(1'b1, 32'h0, 3'd0, 1'b0);
    reset_n = 1'b0;

    // Reset held for 10 cycles, then idle with send_en low.
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("reset%0d l", i), {if_l.tx_done, if_l.uart_state, if_l.uart_tx}, 32'b001);
      chk($sformatf("reset%0d m", i), {if_m.tx_done, if_m.uart_state, if_m.uart_tx}, 32'b001);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle%0d", i),
          {if_l.tx_done, if_l.uart_state, if_l.uart_tx,
           if_m.tx_done, if_m.uart_state, if_m.uart_tx}, 32'b001001);
    end

    for (int i = 0; i < 7; i++) run_word(i, vecs[i]);

    // Abort at 9600 baud: start bit and d0 widths, then reset inside d1.
    sel = 1'b0;
    step();
    drive(1'b0, 32'h00000055, 3'd0, 1'b1);
    step();
    drive(1'b0, 32'h00000055, 3'd0, 1'b0);
    err = 0;
    for (int c = 0; c < 5208; c++) begin
      if (obs_tx !== 1'b0 || obs_state !== 1'b1) err++;
      step();
    end
    chk("abort start_bit_err_cycles", err, 0);
    err = 0;
    for (int c = 0; c < 5208; c++) begin
      if (obs_tx !== 1'b1 || obs_state !== 1'b1) err++;
      step();
    end
    chk("abort d0_err_cycles", err, 0);
    err = 0;
    for (int c = 0; c < 100; c++) begin
      if (obs_tx !== 1'b0 || obs_state !== 1'b1) err++;
      step();
    end
    chk("abort d1_err_cycles", err, 0);
    reset_n = 1'b0;
    step();
    chk("abort first_edge", {29'd0, obs_done, obs_state, obs_tx}, 32'b001);
    err = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      if (obs_done !== 1'b0 || obs_state !== 1'b0 || obs_tx !== 1'b1) err++;
    end
    chk("abort held_err_cycles", err, 0);
    reset_n = 1'b1;
    err = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs_done !== 1'b0 || obs_state !== 1'b0 || obs_tx !== 1'b1) err++;
    end
    chk("abort release_idle_err_cycles", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
